// File: rtl/spm_serial_host.sv
// Initiator for a serial-parallel multiplier core: holds x, streams y LSB-first,
// and deserializes the serial product into a 2*SIZE-bit word behind valid/ready.
module spm_serial_host #(
  parameter int SIZE   = 32,
  parameter bit SIGNED = 1'b1,
  parameter int P_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SIZE-1:0]   a_i,
  input  logic [SIZE-1:0]   b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2*SIZE-1:0] prod_o,
  output logic [SIZE-1:0]   spm_x_o,
  output logic              spm_y_o,
  output logic              spm_rst_o,
  input  logic              spm_p_i
);

  localparam int RUN_LEN = 2*SIZE + P_LAT;
  localparam int CNT_W   = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(2*SIZE - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE-1:0]     bShift_q, bShift_d;
  logic [2*SIZE-1:0]   prod_q, prod_d;
  logic [SIZE-1:0]     spmX_q, spmX_d;
  logic                spmY_q, spmY_d;
  logic                spmRst_q, spmRst_d;
  logic                inReady_q, inReady_d;
  logic                outValid_q, outValid_d;

  logic                sampleEn;
  logic                fillBit;
  logic [SIZE-1:0]     bShiftNext;

  // The product bit for y bit i appears on spm_p_i P_LAT cycles after it is driven.
  generate
    if (P_LAT == 0) begin : g_noLat
      assign sampleEn = 1'b1;
    end else begin : g_lat
      assign sampleEn = (cnt_q >= CNT_W'(P_LAT));
    end
  endgenerate

  // Arithmetic right shift when SIGNED so the upper half of y repeats b's sign bit.
  assign fillBit    = SIGNED ? bShift_q[SIZE-1] : 1'b0;
  assign bShiftNext = {fillBit, bShift_q[SIZE-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bShift_q   <= '0;
      prod_q     <= '0;
      spmX_q     <= '0;
      spmY_q     <= 1'b0;
      spmRst_q   <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bShift_q   <= bShift_d;
      prod_q     <= prod_d;
      spmX_q     <= spmX_d;
      spmY_q     <= spmY_d;
      spmRst_q   <= spmRst_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bShift_d   = bShift_q;
    prod_d     = prod_q;
    spmX_d     = spmX_q;
    spmY_d     = spmY_q;
    spmRst_d   = spmRst_q;
    inReady_d  = inReady_q;
    outValid_d = outValid_q;

    unique case (state_q)
      IDLE: begin
        spmRst_d  = 1'b1;
        spmY_d    = 1'b0;
        inReady_d = 1'b1;
        if (in_valid_i && inReady_q) begin
          spmX_d    = a_i;
          bShift_d  = b_i;
          prod_d    = '0;
          inReady_d = 1'b0;
          spmRst_d  = 1'b0;
          state_d   = CLEAR;
        end
      end

      CLEAR: begin
        state_d  = RUN;
        cnt_d    = '0;
        spmRst_d = 1'b1;
        spmY_d   = bShift_q[0];
        bShift_d = bShiftNext;
      end

      // spmY_d is the y bit for cnt_q+1; beyond 2*SIZE bits y is held at 0.
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sampleEn) begin
          prod_d = {spm_p_i, prod_q[2*SIZE-1:1]};
        end
        if (cnt_q < Y_LAST) begin
          spmY_d   = bShift_q[0];
          bShift_d = bShiftNext;
        end else begin
          spmY_d = 1'b0;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          outValid_d = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: begin
        spmY_d = 1'b0;
        if (outValid_q && out_ready_i) begin
          outValid_d = 1'b0;
          inReady_d  = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign prod_o      = prod_q;
  assign spm_x_o     = spmX_q;
  assign spm_y_o     = spmY_q;
  assign spm_rst_o   = spmRst_q;

endmodule

// File: tb/tb_spm_serial_host.sv
// Directed bench for spm_serial_host: one unsigned and one signed instance, each
// driving a behavioural serial-parallel multiplier with a one-cycle output register.
module tb_spm_serial_host;

  localparam int SIZE  = 8;
  localparam int P_LAT = 1;
  localparam int W     = 2*SIZE;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         sel;
  logic         inValid;
  logic [7:0]   a, b;
  logic         outReady;

  logic         inValidU, inReadyU, outValidU, spmYU, spmRstU, spmPU;
  logic [W-1:0] prodU;
  logic [7:0]   spmXU;
  logic         inValidS, inReadyS, outValidS, spmYS, spmRstS, spmPS;
  logic [W-1:0] prodS;
  logic [7:0]   spmXS;

  logic         inReady, outValid, spmY, spmRst;
  logic [W-1:0] prod;
  logic [7:0]   spmX;

  int checks   = 0;
  int failures = 0;

  assign inValidU = inValid & ~sel;
  assign inValidS = inValid & sel;
  assign inReady  = sel ? inReadyS  : inReadyU;
  assign outValid = sel ? outValidS : outValidU;
  assign prod     = sel ? prodS     : prodU;
  assign spmX     = sel ? spmXS     : spmXU;
  assign spmY     = sel ? spmYS     : spmYU;
  assign spmRst   = sel ? spmRstS   : spmRstU;

  spm_serial_host #(.SIZE(SIZE), .SIGNED(1'b0), .P_LAT(P_LAT)) u_dutU (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValidU), .in_ready_o(inReadyU),
    .a_i(a), .b_i(b), .out_valid_o(outValidU), .out_ready_i(outReady),
    .prod_o(prodU), .spm_x_o(spmXU), .spm_y_o(spmYU), .spm_rst_o(spmRstU),
    .spm_p_i(spmPU));

  spm_serial_host #(.SIZE(SIZE), .SIGNED(1'b1), .P_LAT(P_LAT)) u_dutS (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(inValidS), .in_ready_o(inReadyS),
    .a_i(a), .b_i(b), .out_valid_o(outValidS), .out_ready_i(outReady),
    .prod_o(prodS), .spm_x_o(spmXS), .spm_y_o(spmYS), .spm_rst_o(spmRstS),
    .spm_p_i(spmPS));

  // Behavioural spm: accumulate y_k*x, emit the LSB as product bit k, shift right.
  function automatic logic [W+1:0] spmStep(input logic [W:0] acc, input logic y,
                                           input logic [7:0] x, input bit sgn);
    logic [W:0] xe;
    logic [W:0] t;
    xe = sgn ? {{(W+1-SIZE){x[SIZE-1]}}, x} : {{(W+1-SIZE){1'b0}}, x};
    t  = y ? acc + xe : acc;
    return {1'b0, t[W:1], t[0]};
  endfunction

  logic [W:0]   accU, accS;
  logic [W+1:0] stepU, stepS;
  assign stepU = spmStep(accU, spmYU, spmXU, 1'b0);
  assign stepS = spmStep(accS, spmYS, spmXS, 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accU <= '0; spmPU <= 1'b0; accS <= '0; spmPS <= 1'b0;
    end else begin
      if (!spmRstU) begin accU <= '0; spmPU <= 1'b0; end
      else begin accU <= stepU[W+1:1]; spmPU <= stepU[0]; end
      if (!spmRstS) begin accS <= '0; spmPS <= 1'b0; end
      else begin accS <= stepS[W+1:1]; spmPS <= stepS[0]; end
    end
  end

  // Presents an operand pair and returns at the falling edge inside CLEAR.
  task automatic startOp(input bit s, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    sel = s; a = av; b = bv; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Counts cycles until out_valid, plus cycles with spm_rst low and in_ready high.
  task automatic waitValid(output int lat, output int clr, output int rdy, output bit to);
    to = 1'b1; lat = 0; clr = 0; rdy = 0;
    for (int i = 0; i < 200; i++) begin
      if (!spmRst) clr++;
      if (inReady) rdy++;
      if (outValid) begin to = 1'b0; break; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic takeResult(output logic [W-1:0] res);
    res = prod;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; inValid = 1'b0; outReady = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (inReadyU !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got %b want 1", inReadyU); end
    checks++; if (outValidU !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got %b want 0", outValidU); end
    checks++; if (prodU !== 16'h0000) begin failures++; $display("[TB] FAIL rst_prod got %h want 0000", prodU); end
    checks++; if (spmXU !== 8'h00) begin failures++; $display("[TB] FAIL rst_spm_x got %h want 00", spmXU); end
    checks++; if (spmYU !== 1'b0) begin failures++; $display("[TB] FAIL rst_spm_y got %b want 0", spmYU); end
    checks++; if (spmRstU !== 1'b0) begin failures++; $display("[TB] FAIL rst_spm_rst got %b want 0", spmRstU); end
    checks++; if (inReadyS !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready_s got %b want 1", inReadyS); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (spmRstU !== 1'b0) begin failures++; $display("[TB] FAIL rel_spm_rst_held got %b want 0", spmRstU); end
    @(negedge clk);
    checks++; if (spmRstU !== 1'b1) begin failures++; $display("[TB] FAIL rel_spm_rst_up got %b want 1", spmRstU); end
  endtask

  task automatic test_unsigned_basic();
    int lat, clr, rdy; bit to; logic [W-1:0] res;
    startOp(1'b0, 8'd3, 8'd5);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout got %b want 0", to); end
    checks++; if (lat != 18) begin failures++; $display("[TB] FAIL basic_latency got %0d want 18", lat); end
    checks++; if (clr != 1) begin failures++; $display("[TB] FAIL basic_clear_cycles got %0d want 1", clr); end
    checks++; if (rdy != 0) begin failures++; $display("[TB] FAIL basic_ready_busy got %0d want 0", rdy); end
    takeResult(res);
    checks++; if (res !== 16'h000F) begin failures++; $display("[TB] FAIL basic_prod got %h want 000f", res); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_after got %b want 1", inReady); end
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_after got %b want 0", outValid); end
  endtask

  task automatic test_signed();
    int lat, clr, rdy; bit to; logic [W-1:0] res;
    startOp(1'b1, 8'hFE, 8'h03);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL signed1_timeout got %b want 0", to); end
    takeResult(res);
    checks++; if (res !== 16'hFFFA) begin failures++; $display("[TB] FAIL signed1_prod got %h want fffa", res); end
    startOp(1'b1, 8'h80, 8'h80);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL signed2_timeout got %b want 0", to); end
    takeResult(res);
    checks++; if (res !== 16'h4000) begin failures++; $display("[TB] FAIL signed2_prod got %h want 4000", res); end
  endtask

  task automatic test_back_to_back();
    int lat, clr, rdy; bit to; logic [W-1:0] res;
    startOp(1'b0, 8'hFF, 8'hFF);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0 || rdy != 0) begin failures++; $display("[TB] FAIL b2b1_run got to=%b rdy=%0d want 0 0", to, rdy); end
    takeResult(res);
    checks++; if (res !== 16'hFE01) begin failures++; $display("[TB] FAIL b2b1_prod got %h want fe01", res); end
    startOp(1'b0, 8'h01, 8'h01);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0 || rdy != 0) begin failures++; $display("[TB] FAIL b2b2_run got to=%b rdy=%0d want 0 0", to, rdy); end
    takeResult(res);
    checks++; if (res !== 16'h0001) begin failures++; $display("[TB] FAIL b2b2_prod got %h want 0001", res); end
  endtask

  task automatic test_backpressure();
    int lat, clr, rdy; bit to; logic [W-1:0] res;
    startOp(1'b0, 8'h0C, 8'h0B);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL bp_timeout got %b want 0", to); end
    a = 8'h99; b = 8'h99; inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_hold got %b want 1", outValid); end
      checks++; if (prod !== 16'h0084) begin failures++; $display("[TB] FAIL bp_prod_hold got %h want 0084", prod); end
      checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_low got %b want 0", inReady); end
      checks++; if (spmX !== 8'h0C) begin failures++; $display("[TB] FAIL bp_spm_x got %h want 0c", spmX); end
      checks++; if (spmY !== 1'b0) begin failures++; $display("[TB] FAIL bp_spm_y got %b want 0", spmY); end
      @(negedge clk);
    end
    inValid = 1'b0;
    takeResult(res);
    checks++; if (res !== 16'h0084) begin failures++; $display("[TB] FAIL bp_prod got %h want 0084", res); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_next got %b want 1", inReady); end
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    outReady = 1'b0;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin failures++; $display("[TB] FAIL idle_out_ready got v=%b r=%b want 0 1", outValid, inReady); end
    checks++; if (spmX !== 8'h0C) begin failures++; $display("[TB] FAIL idle_spm_x_kept got %h want 0c", spmX); end
  endtask

  task automatic test_reset_mid_run();
    int lat, clr, rdy; bit to; logic [W-1:0] res;
    startOp(1'b0, 8'h55, 8'h33);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (inReadyU !== 1'b1 || outValidU !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_hs got r=%b v=%b want 1 0", inReadyU, outValidU); end
    checks++; if (prodU !== 16'h0000) begin failures++; $display("[TB] FAIL mid_rst_prod got %h want 0000", prodU); end
    checks++; if (spmXU !== 8'h00 || spmYU !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_x_y got x=%h y=%b want 00 0", spmXU, spmYU); end
    checks++; if (spmRstU !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_spm_rst got %b want 0", spmRstU); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startOp(1'b0, 8'd7, 8'd6);
    waitValid(lat, clr, rdy, to);
    checks++; if (to !== 1'b0 || lat != 18) begin failures++; $display("[TB] FAIL mid_rst_run got to=%b lat=%0d want 0 18", to, lat); end
    takeResult(res);
    checks++; if (res !== 16'h002A) begin failures++; $display("[TB] FAIL mid_rst_prod2 got %h want 002a", res); end
  endtask

  task automatic test_sweep();
    int lat, clr, rdy; bit to; logic [W-1:0] res, expect_v;
    logic [7:0] av, bv;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 100; n++) begin
        av = 8'($urandom); bv = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        startOp(s[0], av, bv);
        waitValid(lat, clr, rdy, to);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        takeResult(res);
        if (s == 1) expect_v = 16'($signed({{8{av[7]}}, av}) * $signed({{8{bv[7]}}, bv}));
        else        expect_v = {8'h00, av} * {8'h00, bv};
        checks++;
        if (to !== 1'b0 || res !== expect_v) begin
          failures++;
          $display("[TB] FAIL sweep s=%0d a=%h b=%h got %h want %h (to=%b)", s, av, bv, res, expect_v, to);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
